vram_port_arbiter: RTL and testbench

// - Owns the GPU's CPU-side VRAM port (we/re/addr/data); shares it between CPU MMIO accesses and a

---
 rtl/gpu_pkg.sv | 28 ++
 rtl/vram_port_arbiter_if.sv | 16 +
 rtl/rect_fill_seq.sv | 106 ++++++++++
 rtl/vram_port_arbiter.sv | 110 +++++++++++
 tb/tb_vram_port_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared parameters and types for the CPU-side VRAM port arbiter and its
// rectangle-fill engine.
package gpu_pkg;

   localparam int H_RES  = 200;
   localparam int V_RES  = 150;
   localparam int DATA_W = 12;
   localparam int ADDR_W = 16;

   localparam logic [7:0] H_MAX = 8'(H_RES - 1);
   localparam logic [7:0] V_MAX = 8'(V_RES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fill_state_t;

   typedef enum logic {
      CPU,
      FILL
   } requester_t;

   function automatic logic [7:0] clampCoord(input logic [7:0] coord, input logic [7:0] maxVal);
      return (coord > maxVal) ? maxVal : coord;
   endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// CPU MMIO request/response bus into the VRAM port arbiter.
interface vram_port_arbiter_if;
   import gpu_pkg::*;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;

   modport master (output req, we, addr, wdata, input  ack, rdata, rvalid);
   modport slave  (input  req, we, addr, wdata, output ack, rdata, rvalid);

endinterface

// File: rtl/rect_fill_seq.sv
// Rectangle-fill sequencer: walks the clamped rectangle row by row and
// requests one pixel write per cycle, advancing only when granted.
module rect_fill_seq
   import gpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              fill_start_i,
   input  logic [7:0]        fill_x0_i,
   input  logic [7:0]        fill_y0_i,
   input  logic [7:0]        fill_x1_i,
   input  logic [7:0]        fill_y1_i,
   input  logic [DATA_W-1:0] fill_color_i,
   input  logic              fill_gnt_i,
   output logic              fill_req_o,
   output logic [ADDR_W-1:0] fill_addr_o,
   output logic [DATA_W-1:0] fill_color_o,
   output logic              fill_busy_o,
   output logic              fill_done_o
);

   fill_state_t       r_state, w_stateNext;
   logic [7:0]        r_h, r_v, r_x0, r_x1, r_y1;
   logic [7:0]        w_hNext, w_vNext, w_x0Next, w_x1Next, w_y1Next;
   logic [DATA_W-1:0] r_color, w_colorNext;
   logic              r_busy, r_done;
   logic [7:0]        w_x1Clamp, w_y1Clamp;
   logic              w_empty;

   assign w_x1Clamp = clampCoord(fill_x1_i, H_MAX);
   assign w_y1Clamp = clampCoord(fill_y1_i, V_MAX);
   assign w_empty   = (fill_x0_i > w_x1Clamp) || (fill_y0_i > w_y1Clamp) ||
                      (fill_x0_i > H_MAX)     || (fill_y0_i > V_MAX);

   // Next-state and counter update; h wraps to x0 at the row end and the
   // grant on the bottom-right pixel ends the fill.
   always_comb begin
      w_stateNext = r_state;
      w_hNext     = r_h;
      w_vNext     = r_v;
      w_x0Next    = r_x0;
      w_x1Next    = r_x1;
      w_y1Next    = r_y1;
      w_colorNext = r_color;
      case (r_state)
         IDLE: begin
            if (fill_start_i) begin
               w_x0Next    = fill_x0_i;
               w_x1Next    = w_x1Clamp;
               w_y1Next    = w_y1Clamp;
               w_colorNext = fill_color_i;
               w_hNext     = fill_x0_i;
               w_vNext     = fill_y0_i;
               w_stateNext = w_empty ? DONE : RUN;
            end
         end
         RUN: begin
            if (fill_gnt_i) begin
               if (r_h == r_x1) begin
                  w_hNext = r_x0;
                  if (r_v == r_y1) begin
                     w_stateNext = DONE;
                  end else begin
                     w_vNext = r_v + 8'd1;
                  end
               end else begin
                  w_hNext = r_h + 8'd1;
               end
            end
         end
         DONE:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_h     <= '0;
         r_v     <= '0;
         r_x0    <= '0;
         r_x1    <= '0;
         r_y1    <= '0;
         r_color <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_h     <= w_hNext;
         r_v     <= w_vNext;
         r_x0    <= w_x0Next;
         r_x1    <= w_x1Next;
         r_y1    <= w_y1Next;
         r_color <= w_colorNext;
         r_busy  <= (w_stateNext != IDLE);
         r_done  <= (r_state == DONE);
      end
   end

   assign fill_req_o   = (r_state == RUN);
   assign fill_addr_o  = {r_v, r_h};
   assign fill_color_o = r_color;
   assign fill_busy_o  = r_busy;
   assign fill_done_o  = r_done;

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares the GPU's CPU-side VRAM port between CPU MMIO and the fill engine,
// one registered access per cycle with round-robin arbitration.
module vram_port_arbiter
   import gpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   vram_port_arbiter_if.slave   cpu_bus,
   input  logic                 fill_start_i,
   input  logic [7:0]           fill_x0_i,
   input  logic [7:0]           fill_y0_i,
   input  logic [7:0]           fill_x1_i,
   input  logic [7:0]           fill_y1_i,
   input  logic [DATA_W-1:0]    fill_color_i,
   output logic                 fill_busy_o,
   output logic                 fill_done_o,
   output logic                 vram_we_o,
   output logic                 vram_re_o,
   output logic [ADDR_W-1:0]    vram_addr_o,
   output logic [DATA_W-1:0]    vram_wdata_o,
   input  logic [DATA_W-1:0]    vram_rdata_i
);

   logic              w_fillReq, w_fillGnt, w_cpuReq, w_grant;
   logic [ADDR_W-1:0] w_fillAddr;
   logic [DATA_W-1:0] w_fillColor;
   requester_t        w_winner, r_rrLast;
   logic              r_we, r_re, r_ack, r_rvalid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   rect_fill_seq u_fill (
      .clk          (clk),
      .rst          (rst),
      .fill_start_i (fill_start_i),
      .fill_x0_i    (fill_x0_i),
      .fill_y0_i    (fill_y0_i),
      .fill_x1_i    (fill_x1_i),
      .fill_y1_i    (fill_y1_i),
      .fill_color_i (fill_color_i),
      .fill_gnt_i   (w_fillGnt),
      .fill_req_o   (w_fillReq),
      .fill_addr_o  (w_fillAddr),
      .fill_color_o (w_fillColor),
      .fill_busy_o  (fill_busy_o),
      .fill_done_o  (fill_done_o)
   );

   // The CPU still holds req during its ack cycle, so that cycle is masked.
   assign w_cpuReq = cpu_bus.req & ~r_ack;

   always_comb begin
      w_grant  = 1'b0;
      w_winner = CPU;
      if (w_cpuReq && w_fillReq) begin
         w_grant  = 1'b1;
         w_winner = (r_rrLast == CPU) ? FILL : CPU;
      end else if (w_cpuReq) begin
         w_grant  = 1'b1;
         w_winner = CPU;
      end else if (w_fillReq) begin
         w_grant  = 1'b1;
         w_winner = FILL;
      end
   end

   assign w_fillGnt = w_grant && (w_winner == FILL);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rrLast <= FILL;
         r_we     <= 1'b0;
         r_re     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_ack    <= 1'b0;
         r_rvalid <= 1'b0;
      end else begin
         r_we     <= 1'b0;
         r_re     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_ack    <= 1'b0;
         r_rvalid <= r_re;
         if (w_grant) begin
            r_rrLast <= w_winner;
            if (w_winner == CPU) begin
               r_we    <= cpu_bus.we;
               r_re    <= ~cpu_bus.we;
               r_addr  <= cpu_bus.addr;
               r_wdata <= cpu_bus.we ? cpu_bus.wdata : '0;
               r_ack   <= 1'b1;
            end else begin
               r_we    <= 1'b1;
               r_addr  <= w_fillAddr;
               r_wdata <= w_fillColor;
            end
         end
      end
   end

   assign vram_we_o      = r_we;
   assign vram_re_o      = r_re;
   assign vram_addr_o    = r_addr;
   assign vram_wdata_o   = r_wdata;
   assign cpu_bus.ack    = r_ack;
   assign cpu_bus.rvalid = r_rvalid;
   assign cpu_bus.rdata  = r_rvalid ? vram_rdata_i : '0;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a small synchronous VRAM model.
module tb_vram_port_arbiter;
   import gpu_pkg::*;

   logic              clk;
   logic              rst;
   logic              fillStart;
   logic [7:0]        fillX0, fillY0, fillX1, fillY1;
   logic [DATA_W-1:0] fillColor;
   logic              fillBusy, fillDone;
   logic              vramWe, vramRe;
   logic [ADDR_W-1:0] vramAddr;
   logic [DATA_W-1:0] vramWdata;
   logic [DATA_W-1:0] vramRdata;
   logic [DATA_W-1:0] vramMem [0:65535];
   int                checks;
   int                errors;

   vram_port_arbiter_if cpuBus ();

   vram_port_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_bus      (cpuBus.slave),
      .fill_start_i (fillStart),
      .fill_x0_i    (fillX0),
      .fill_y0_i    (fillY0),
      .fill_x1_i    (fillX1),
      .fill_y1_i    (fillY1),
      .fill_color_i (fillColor),
      .fill_busy_o  (fillBusy),
      .fill_done_o  (fillDone),
      .vram_we_o    (vramWe),
      .vram_re_o    (vramRe),
      .vram_addr_o  (vramAddr),
      .vram_wdata_o (vramWdata),
      .vram_rdata_i (vramRdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // VRAM stand-in: write on the strobe, read data appears one cycle later.
   always @(posedge clk) begin
      if (vramWe) vramMem[vramAddr] <= vramWdata;
      if (vramRe) vramRdata <= vramMem[vramAddr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic startFill(input logic [7:0] x0, input logic [7:0] y0,
                            input logic [7:0] x1, input logic [7:0] y1,
                            input logic [DATA_W-1:0] color);
      fillX0    = x0;
      fillY0    = y0;
      fillX1    = x1;
      fillY1    = y1;
      fillColor = color;
      fillStart = 1'b1;
      tick();
      fillStart = 1'b0;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      fillStart    = 1'b0;
      cpuBus.req   = 1'b0;
      cpuBus.we    = 1'b0;
      cpuBus.addr  = '0;
      cpuBus.wdata = '0;
      repeat (3) tick();
      checks++;
      if ({vramWe, vramRe, vramAddr, vramWdata} !== 30'd0) begin
         errors++;
         $display("[TB] FAIL reset_vram: got %h expected 0", {vramWe, vramRe, vramAddr, vramWdata});
      end
      checks++;
      if ({cpuBus.ack, cpuBus.rvalid, cpuBus.rdata} !== 14'd0) begin
         errors++;
         $display("[TB] FAIL reset_cpu: got %h expected 0", {cpuBus.ack, cpuBus.rvalid, cpuBus.rdata});
      end
      checks++;
      if ({fillBusy, fillDone} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_fill: got %b expected 00", {fillBusy, fillDone});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_cpu_access();
      cpuBus.req   = 1'b1;
      cpuBus.we    = 1'b1;
      cpuBus.addr  = 16'h0A05;
      cpuBus.wdata = 12'hF00;
      tick();
      cpuBus.req = 1'b0;
      checks++;
      if ({cpuBus.ack, vramWe, vramRe, vramAddr, vramWdata} !== {3'b110, 16'h0A05, 12'hF00}) begin
         errors++;
         $display("[TB] FAIL cpu_write_issue: got %h expected %h",
                  {cpuBus.ack, vramWe, vramRe, vramAddr, vramWdata}, {3'b110, 16'h0A05, 12'hF00});
      end
      tick();
      checks++;
      if ({cpuBus.ack, vramWe} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL cpu_ack_pulse: got %b expected 00", {cpuBus.ack, vramWe});
      end
      cpuBus.req = 1'b1;
      cpuBus.we  = 1'b0;
      tick();
      cpuBus.req = 1'b0;
      checks++;
      if ({cpuBus.ack, vramWe, vramRe, cpuBus.rvalid, vramAddr} !== {4'b1010, 16'h0A05}) begin
         errors++;
         $display("[TB] FAIL cpu_read_issue: got %h expected %h",
                  {cpuBus.ack, vramWe, vramRe, cpuBus.rvalid, vramAddr}, {4'b1010, 16'h0A05});
      end
      tick();
      checks++;
      if ({cpuBus.rvalid, cpuBus.rdata} !== {1'b1, 12'hF00}) begin
         errors++;
         $display("[TB] FAIL cpu_read_data: got %h expected %h", {cpuBus.rvalid, cpuBus.rdata}, {1'b1, 12'hF00});
      end
      tick();
      checks++;
      if (cpuBus.rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cpu_rvalid_pulse: got %b expected 0", cpuBus.rvalid);
      end
   endtask

   task automatic test_small_fill();
      logic [ADDR_W-1:0] expAddr [6] = '{16'h0302, 16'h0303, 16'h0304, 16'h0402, 16'h0403, 16'h0404};
      logic [ADDR_W-1:0] seen [$];
      int firstWe, lastWe, doneAt, doneCount, badData;
      firstWe = -1; lastWe = -1; doneAt = -1; doneCount = 0; badData = 0;
      startFill(8'd2, 8'd3, 8'd4, 8'd4, 12'h0F0);
      checks++;
      if (fillBusy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL small_busy_set: got %b expected 1", fillBusy);
      end
      for (int i = 0; i < 20; i++) begin
         if (vramWe) begin
            seen.push_back(vramAddr);
            if (vramWdata !== 12'h0F0) badData++;
            if (firstWe < 0) firstWe = i;
            lastWe = i;
         end
         if (fillDone) begin
            doneCount++;
            doneAt = i;
         end
         tick();
      end
      checks++;
      if (seen.size() !== 6) begin
         errors++;
         $display("[TB] FAIL small_count: got %0d expected 6", seen.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (seen[i] !== expAddr[i]) begin
               errors++;
               $display("[TB] FAIL small_addr%0d: got %h expected %h", i, seen[i], expAddr[i]);
            end
         end
      end
      checks++;
      if (badData !== 0 || (lastWe - firstWe) !== 5) begin
         errors++;
         $display("[TB] FAIL small_data_rate: bad %0d span %0d expected 0 and 5", badData, lastWe - firstWe);
      end
      checks++;
      if (doneCount !== 1 || doneAt !== lastWe + 1) begin
         errors++;
         $display("[TB] FAIL small_done: count %0d at %0d expected 1 at %0d", doneCount, doneAt, lastWe + 1);
      end
      checks++;
      if (fillBusy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL small_busy_clear: got %b expected 0", fillBusy);
      end
   endtask

   task automatic test_clamped_fill();
      int writes, outOfRange, cycles;
      logic [ADDR_W-1:0] firstAddr, lastAddr;
      logic doneSeen;
      writes = 0; outOfRange = 0; cycles = 0; doneSeen = 1'b0;
      firstAddr = '1; lastAddr = '0;
      startFill(8'd0, 8'd0, 8'd255, 8'd255, 12'h00F);
      while (!doneSeen && cycles < 31000) begin
         if (vramWe) begin
            if (writes == 0) firstAddr = vramAddr;
            lastAddr = vramAddr;
            writes++;
            if (vramAddr[7:0] > 8'd199 || vramAddr[15:8] > 8'd149) outOfRange++;
         end
         doneSeen = fillDone;
         cycles++;
         tick();
      end
      checks++;
      if (!doneSeen) begin
         errors++;
         $display("[TB] FAIL clamp_timeout: done not seen within %0d cycles", cycles);
      end
      checks++;
      if (writes !== 30000) begin
         errors++;
         $display("[TB] FAIL clamp_count: got %0d expected 30000", writes);
      end
      checks++;
      if (firstAddr !== 16'h0000 || lastAddr !== 16'h95C7 || outOfRange !== 0) begin
         errors++;
         $display("[TB] FAIL clamp_addr: first %h last %h oor %0d expected 0000 95c7 0", firstAddr, lastAddr, outOfRange);
      end
   endtask

   task automatic test_empty_fill();
      int weCount;
      weCount = 0;
      startFill(8'd10, 8'd0, 8'd5, 8'd0, 12'hFFF);
      if (vramWe) weCount++;
      checks++;
      if ({fillBusy, fillDone} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL empty_cycle1: got %b expected 10", {fillBusy, fillDone});
      end
      tick();
      if (vramWe) weCount++;
      checks++;
      if (fillDone !== 1'b1) begin
         errors++;
         $display("[TB] FAIL empty_done: got %b expected 1", fillDone);
      end
      tick();
      if (vramWe) weCount++;
      checks++;
      if (fillDone !== 1'b0 || weCount !== 0) begin
         errors++;
         $display("[TB] FAIL empty_after: done %b writes %0d expected 0 0", fillDone, weCount);
      end
   endtask

   task automatic test_back_to_back();
      string expKinds = "CFCFCFCF";
      logic [ADDR_W-1:0] expAddr [4] = '{16'h2010, 16'h2011, 16'h2110, 16'h2111};
      logic [ADDR_W-1:0] fillSeen [$];
      byte kind;
      int badData, doneCount;
      badData = 0; doneCount = 0;
      cpuBus.req   = 1'b1;
      cpuBus.we    = 1'b1;
      cpuBus.addr  = 16'h7777;
      cpuBus.wdata = 12'h123;
      startFill(8'h10, 8'h20, 8'h11, 8'h21, 12'hABC);
      for (int i = 0; i < 8; i++) begin
         if (cpuBus.ack) begin
            kind = "C";
            if (vramAddr !== 16'h7777 || vramWdata !== 12'h123) badData++;
         end else if (vramWe) begin
            kind = "F";
            fillSeen.push_back(vramAddr);
            if (vramWdata !== 12'hABC) badData++;
         end else begin
            kind = "-";
         end
         checks++;
         if (kind !== expKinds[i]) begin
            errors++;
            $display("[TB] FAIL contend_grant%0d: got %s expected %s", i, kind, expKinds[i]);
         end
         if (i < 7) tick();
      end
      cpuBus.req = 1'b0;
      checks++;
      if (fillSeen.size() !== 4 || badData !== 0) begin
         errors++;
         $display("[TB] FAIL contend_writes: got %0d bad %0d expected 4 0", fillSeen.size(), badData);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (fillSeen[i] !== expAddr[i]) begin
               errors++;
               $display("[TB] FAIL contend_addr%0d: got %h expected %h", i, fillSeen[i], expAddr[i]);
            end
         end
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         if (fillDone) doneCount++;
      end
      checks++;
      if (doneCount !== 1 || fillBusy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL contend_done: count %0d busy %b expected 1 0", doneCount, fillBusy);
      end
   endtask

   task automatic test_reset_mid_op();
      int doneCount, weCount;
      doneCount = 0; weCount = 0;
      cpuBus.req = 1'b1;
      cpuBus.we  = 1'b0;
      cpuBus.addr = 16'h0A05;
      tick();
      cpuBus.req = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({cpuBus.rvalid, cpuBus.rdata} !== 13'd0) begin
         errors++;
         $display("[TB] FAIL rst_rvalid: got %h expected 0", {cpuBus.rvalid, cpuBus.rdata});
      end
      startFill(8'd0, 8'd0, 8'd9, 8'd9, 12'h777);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({vramWe, fillBusy, fillDone} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL rst_fill_stop: got %b expected 000", {vramWe, fillBusy, fillDone});
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         if (fillDone) doneCount++;
         if (vramWe) weCount++;
      end
      checks++;
      if (doneCount !== 0 || weCount !== 0) begin
         errors++;
         $display("[TB] FAIL rst_fill_quiet: done %0d writes %0d expected 0 0", doneCount, weCount);
      end
      startFill(8'd0, 8'd0, 8'd0, 8'd0, 12'h555);
      checks++;
      if (fillBusy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_restart_busy: got %b expected 1", fillBusy);
      end
      for (int i = 0; i < 6; i++) begin
         if (vramWe && vramAddr === 16'h0000 && vramWdata === 12'h555) weCount++;
         if (fillDone) doneCount++;
         tick();
      end
      checks++;
      if (weCount !== 1 || doneCount !== 1) begin
         errors++;
         $display("[TB] FAIL rst_restart_fill: writes %0d done %0d expected 1 1", weCount, doneCount);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_cpu_access();
      test_small_fill();
      test_clamped_fill();
      test_empty_fill();
      test_back_to_back();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
